ccc_lock_supervisor: RTL and testbench

Consumer-side supervisor for the MSS clock conditioning circuit outputs. It qualifies the CCC lock indication, checks the frequency of the secondary global clock GLB against FAB_CLK, and holds the fabric reset until both checks pass. After release it keeps monitoring, re-asserts the fabric reset on lock loss or frequency fault, and counts lock-loss events. It sits between the MSS CCC block (FAB_LOCK, GLB) and all fabric logic clocked by FAB_CLK.

---
 rtl/ccc_lock_supervisor.sv | 141 ++++++++++++++
 tb/tb_ccc_lock_supervisor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ccc_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : ccc_lock_supervisor
// Description : Qualifies CCC lock and GLB frequency, gates the fabric reset.
// Revision    : 1.0 - initial release
// ============================================================================
module ccc_lock_supervisor #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int REF_WINDOW         = 256,
    parameter int EXP_EDGES          = 85,
    parameter int TOL                = 2,
    parameter int CNT_W              = 10
) (
    input  logic             FAB_CLK,
    input  logic             M2F_RESET_N,
    input  logic             FAB_LOCK,
    input  logic             GLB,
    input  logic             CLR_FAULT,
    output logic             FABRIC_RESET_N,
    output logic             READY,
    output logic             FAULT,
    output logic [CNT_W-1:0] LAST_EDGES,
    output logic [7:0]       LOSS_CNT,
    output logic [2:0]       STATE
);

    localparam int STAB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int WIN_W  = (REF_WINDOW > 1) ? $clog2(REF_WINDOW) : 1;

    localparam logic [STAB_W-1:0] c_stab_last = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [WIN_W-1:0]  c_win_last  = WIN_W'(REF_WINDOW - 1);
    localparam logic [CNT_W-1:0]  c_exp       = CNT_W'(EXP_EDGES);
    localparam logic [CNT_W-1:0]  c_tol       = CNT_W'(TOL);

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_STABLE    = 3'd1,
        S_MEASURE   = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [SYNC_STAGES-1:0]  r_lock_sync;
    logic [SYNC_STAGES-1:0]  r_glb_sync;
    logic                    r_glb_d;
    logic [STAB_W-1:0]       r_stab_cnt;
    logic [WIN_W-1:0]        r_win_cnt;
    logic [CNT_W-1:0]        r_edge_cnt;

    logic                    w_lock_s;
    logic                    w_glb_s;
    logic                    w_rise;
    logic                    w_windowing;
    logic                    w_win_end;
    logic [CNT_W-1:0]        w_total;
    logic [CNT_W-1:0]        w_diff;
    logic                    w_pass;

    assign w_lock_s    = r_lock_sync[SYNC_STAGES-1];
    assign w_glb_s     = r_glb_sync[SYNC_STAGES-1];
    assign w_rise      = w_glb_s & ~r_glb_d;
    assign w_windowing = (r_state == S_MEASURE) || (r_state == S_RUN);
    assign w_win_end   = w_windowing && (r_win_cnt == c_win_last);

    // Running count including this cycle's rise; saturates rather than wrapping.
    assign w_total = (&r_edge_cnt) ? r_edge_cnt : (r_edge_cnt + CNT_W'(w_rise));
    assign w_diff  = (w_total >= c_exp) ? (w_total - c_exp) : (c_exp - w_total);
    assign w_pass  = (w_diff <= c_tol);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT_LOCK: if (w_lock_s) w_next = S_STABLE;
            S_STABLE: begin
                if (!w_lock_s)                      w_next = S_WAIT_LOCK;
                else if (r_stab_cnt == c_stab_last) w_next = S_MEASURE;
            end
            S_MEASURE: begin
                if (!w_lock_s)      w_next = S_WAIT_LOCK;
                else if (w_win_end) w_next = w_pass ? S_RUN : S_FAULT;
            end
            S_RUN: begin
                if (!w_lock_s)                 w_next = S_WAIT_LOCK;
                else if (w_win_end && !w_pass) w_next = S_FAULT;
            end
            S_FAULT:     if (CLR_FAULT) w_next = S_WAIT_LOCK;
            default:     w_next = S_WAIT_LOCK;
        endcase
    end

    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            r_state        <= S_WAIT_LOCK;
            r_lock_sync    <= '0;
            r_glb_sync     <= '0;
            r_glb_d        <= 1'b0;
            r_stab_cnt     <= '0;
            r_win_cnt      <= '0;
            r_edge_cnt     <= '0;
            FABRIC_RESET_N <= 1'b0;
            READY          <= 1'b0;
            FAULT          <= 1'b0;
            LAST_EDGES     <= '0;
            LOSS_CNT       <= '0;
        end else begin
            r_lock_sync    <= {r_lock_sync[SYNC_STAGES-2:0], FAB_LOCK};
            r_glb_sync     <= {r_glb_sync[SYNC_STAGES-2:0], GLB};
            r_glb_d        <= w_glb_s;
            r_state        <= w_next;
            FABRIC_RESET_N <= (w_next == S_RUN);
            READY          <= (w_next == S_RUN);
            FAULT          <= (w_next == S_FAULT);

            if (r_state == S_STABLE) r_stab_cnt <= r_stab_cnt + STAB_W'(1);
            else                     r_stab_cnt <= '0;

            // Windows run back-to-back; LAST_EDGES updates even when lock loss wins.
            if (w_win_end) begin
                LAST_EDGES <= w_total;
                r_win_cnt  <= '0;
                r_edge_cnt <= '0;
            end else if (w_windowing) begin
                r_win_cnt  <= r_win_cnt + WIN_W'(1);
                r_edge_cnt <= w_total;
            end else begin
                r_win_cnt  <= '0;
                r_edge_cnt <= '0;
            end

            if ((r_state == S_RUN) && !w_lock_s && (LOSS_CNT != 8'hFF))
                LOSS_CNT <= LOSS_CNT + 8'd1;
        end
    end

    assign STATE = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ccc_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccc_lock_supervisor
// Description : Directed self-checking bench for ccc_lock_supervisor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccc_lock_supervisor;

    logic       clk;
    logic       rst_n;
    logic       fab_lock;
    logic       glb;
    logic       clr_fault;
    logic       fabric_reset_n;
    logic       ready;
    logic       fault;
    logic [9:0] last_edges;
    logic [7:0] loss_cnt;
    logic [2:0] state;

    int n_cmp  = 0;
    int n_fail = 0;
    int glb_div = 3;
    int glb_ph  = 0;

    ccc_lock_supervisor #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (16),
        .REF_WINDOW         (30),
        .EXP_EDGES          (10),
        .TOL                (1),
        .CNT_W              (10)
    ) dut (
        .FAB_CLK        (clk),
        .M2F_RESET_N    (rst_n),
        .FAB_LOCK       (fab_lock),
        .GLB            (glb),
        .CLR_FAULT      (clr_fault),
        .FABRIC_RESET_N (fabric_reset_n),
        .READY          (ready),
        .FAULT          (fault),
        .LAST_EDGES     (last_edges),
        .LOSS_CNT       (loss_cnt),
        .STATE          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GLB = FAB_CLK/glb_div, or held low when glb_div is 0.
    initial begin
        glb = 1'b0;
        forever begin
            @(negedge clk);
            if (glb_div == 0) begin
                glb = 1'b0;
            end else begin
                glb_ph = (glb_ph + 1) % glb_div;
                glb    = (glb_ph == 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rstn"},  32'(fabric_reset_n), 32'd0);
        check({tag, "_ready"}, 32'(ready),          32'd0);
        check({tag, "_fault"}, 32'(fault),          32'd0);
        check({tag, "_last"},  32'(last_edges),     32'd0);
        check({tag, "_loss"},  32'(loss_cnt),       32'd0);
        check({tag, "_state"}, 32'(state),          32'd0);
    endtask

    // Holds reset for two edges; the first posedge after return is edge 1.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n     = 1'b0;
        fab_lock  = 1'b0;
        clr_fault = 1'b0;
        #1;
        check_reset_vals(tag);
        tick(2);
        @(negedge clk);
        rst_n    = 1'b1;
        fab_lock = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        fab_lock  = 1'b0;
        clr_fault = 1'b0;
        tick(2);

        // Clean bring-up
        do_reset("por");
        tick(2);  check("up_e2_state",  32'(state), 32'd0);
        tick(1);  check("up_e3_state",  32'(state), 32'd1);
        tick(15); check("up_e18_state", 32'(state), 32'd1);
        tick(1);  check("up_e19_state", 32'(state), 32'd2);
        tick(29); check("up_e48_state", 32'(state), 32'd2);
        check("up_e48_rstn", 32'(fabric_reset_n), 32'd0);
        tick(1);
        check("up_e49_rstn",  32'(fabric_reset_n), 32'd1);
        check("up_e49_ready", 32'(ready),          32'd1);
        check("up_e49_last",  32'(last_edges),     32'd10);
        check("up_e49_loss",  32'(loss_cnt),       32'd0);
        check("up_e49_state", 32'(state),          32'd3);

        // Lock loss in RUN, relock, then saturate LOSS_CNT
        @(negedge clk); fab_lock = 1'b0;
        tick(2); check("loss_e2_rstn", 32'(fabric_reset_n), 32'd1);
        tick(1);
        check("loss_e3_rstn",  32'(fabric_reset_n), 32'd0);
        check("loss_e3_state", 32'(state),          32'd0);
        check("loss_e3_cnt",   32'(loss_cnt),       32'd1);
        @(negedge clk); fab_lock = 1'b1;
        tick(48); check("relock_e48_ready", 32'(ready), 32'd0);
        tick(1);
        check("relock_e49_ready", 32'(ready),    32'd1);
        check("relock_e49_cnt",   32'(loss_cnt), 32'd1);
        for (int i = 0; i < 298; i++) begin
            @(negedge clk); fab_lock = 1'b0;
            tick(3);
            @(negedge clk); fab_lock = 1'b1;
            tick(49);
        end
        check("loss299_ready", 32'(ready), 32'd1);
        @(negedge clk); fab_lock = 1'b0;
        tick(3);
        check("loss300_cnt",   32'(loss_cnt), 32'd255);
        check("loss300_state", 32'(state),    32'd0);

        // Lock glitch during STABLE
        do_reset("glitch_rst");
        tick(3); check("gl_e3_state", 32'(state), 32'd1);
        tick(5);
        @(negedge clk); fab_lock = 1'b0;
        tick(3); check("gl_e11_state", 32'(state), 32'd0);
        @(negedge clk); fab_lock = 1'b1;
        tick(2);  check("gl_e13_state", 32'(state), 32'd0);
        tick(1);  check("gl_e14_state", 32'(state), 32'd1);
        tick(15); check("gl_e29_state", 32'(state), 32'd1);
        tick(1);  check("gl_e30_state", 32'(state), 32'd2);
        tick(29); check("gl_e59_rstn",  32'(fabric_reset_n), 32'd0);
        tick(1);
        check("gl_e60_rstn", 32'(fabric_reset_n), 32'd1);
        check("gl_e60_loss", 32'(loss_cnt),       32'd0);

        // Wrong frequency
        glb_div = 4;
        do_reset("wf_rst");
        tick(48); check("wf_e48_state", 32'(state), 32'd2);
        tick(1);
        check("wf_e49_fault", 32'(fault),          32'd1);
        check("wf_e49_rstn",  32'(fabric_reset_n), 32'd0);
        check("wf_e49_ready", 32'(ready),          32'd0);
        check("wf_e49_state", 32'(state),          32'd4);
        check("wf_e49_last_7_8", 32'(last_edges == 10'd7 || last_edges == 10'd8), 32'd1);
        @(negedge clk); fab_lock = 1'b0;
        tick(5); check("wf_lockoff_state", 32'(state), 32'd4);
        @(negedge clk); fab_lock = 1'b1;
        tick(5); check("wf_lockon_state", 32'(state), 32'd4);
        check("wf_lockon_fault", 32'(fault), 32'd1);
        @(negedge clk); clr_fault = 1'b1;
        tick(1);
        check("wf_clr_state", 32'(state), 32'd0);
        check("wf_clr_fault", 32'(fault), 32'd0);
        @(negedge clk); clr_fault = 1'b0;

        // GLB stops at RUN entry (as seen through the synchronizer)
        glb_div = 3;
        do_reset("stop_rst");
        tick(46);
        @(negedge clk); glb_div = 0; glb = 1'b0;
        tick(3);  check("stop_e49_ready", 32'(ready), 32'd1);
        tick(29); check("stop_e78_state", 32'(state), 32'd3);
        tick(1);
        check("stop_e79_fault", 32'(fault),          32'd1);
        check("stop_e79_rstn",  32'(fabric_reset_n), 32'd0);
        check("stop_e79_last",  32'(last_edges),     32'd0);
        check("stop_e79_state", 32'(state),          32'd4);

        // Reset mid-MEASURE
        glb_div = 3;
        do_reset("mid_rst0");
        tick(34); check("mid_e34_state", 32'(state), 32'd2);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("mid_async");
        @(negedge clk); rst_n = 1'b1;
        tick(48); check("mid_e48_state", 32'(state), 32'd2);
        tick(1);
        check("mid_e49_ready", 32'(ready),          32'd1);
        check("mid_e49_rstn",  32'(fabric_reset_n), 32'd1);
        check("mid_e49_last",  32'(last_edges),     32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
